// File: rtl/regmux_n.sv
// Registered N:1 word selector with valid/ready on both sides.
// A main output register plus one skid entry sustain full throughput under backpressure.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module regmux_n #(
  parameter  int SIGNAL_WIDTH = `REG_WIDTH,
  parameter  int NUM_INPUTS   = 8,
  localparam int SEL_WIDTH    = $clog2(NUM_INPUTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_INPUTS*SIGNAL_WIDTH-1:0] in_bus,
  input  logic [SEL_WIDTH-1:0]               selector,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [SIGNAL_WIDTH-1:0]            out,
  output logic [SEL_WIDTH-1:0]               out_sel,
  output logic                               out_err,
  output logic                               out_valid,
  input  logic                               out_ready
);

  // Handshake: a word moves on a rising clk when valid & ready are both high on
  // that side; a producer holds its payload stable while valid is high and ready low.

  typedef struct packed {
    logic                    err;
    logic [SEL_WIDTH-1:0]    sel;
    logic [SIGNAL_WIDTH-1:0] data;
  } entry_t;

  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   out_valid_q;
  logic   skid_valid_q;
  logic   live_q;
  logic   accept;
  logic   out_xfer;
  logic   main_free;

  always_comb begin
    in_entry      = '0;
    in_entry.sel  = selector;
    in_entry.err  = ({{(32-SEL_WIDTH){1'b0}}, selector} >= 32'(NUM_INPUTS));
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (selector == SEL_WIDTH'(k)) begin
        in_entry.data = in_bus[k*SIGNAL_WIDTH +: SIGNAL_WIDTH];
      end
    end
  end

  // live_q keeps in_ready low until the first clock after reset release.
  assign in_ready  = live_q & ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;
  assign main_free = out_xfer | ~out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (skid_valid_q && out_xfer) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (accept && main_free) begin
        main_q      <= in_entry;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        skid_q       <= in_entry;
        skid_valid_q <= 1'b1;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out       = main_q.data;
  assign out_sel   = main_q.sel;
  assign out_err   = main_q.err;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_regmux_n.sv
// Directed and scoreboarded bench for regmux_n with 8-, 5- and 3-input builds.
module tb_regmux_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 8-input build
  logic [63:0] bus8;
  logic [2:0]  sel8, out_sel8;
  logic        iv8, in_ready8, out_err8, out_valid8, out_ready8;
  logic [7:0]  out8;
  regmux_n #(.SIGNAL_WIDTH(8), .NUM_INPUTS(8)) dut8 (
    .clk(clk), .rst(rst), .in_bus(bus8), .selector(sel8), .in_valid(iv8),
    .in_ready(in_ready8), .out(out8), .out_sel(out_sel8), .out_err(out_err8),
    .out_valid(out_valid8), .out_ready(out_ready8));

  // 5-input build
  logic [39:0] bus5;
  logic [2:0]  sel5, out_sel5;
  logic        iv5, in_ready5, out_err5, out_valid5, out_ready5;
  logic [7:0]  out5;
  regmux_n #(.SIGNAL_WIDTH(8), .NUM_INPUTS(5)) dut5 (
    .clk(clk), .rst(rst), .in_bus(bus5), .selector(sel5), .in_valid(iv5),
    .in_ready(in_ready5), .out(out5), .out_sel(out_sel5), .out_err(out_err5),
    .out_valid(out_valid5), .out_ready(out_ready5));

  // 3-input build
  logic [23:0] bus3;
  logic [1:0]  sel3, out_sel3;
  logic        iv3, in_ready3, out_err3, out_valid3, out_ready3;
  logic [7:0]  out3;
  regmux_n #(.SIGNAL_WIDTH(8), .NUM_INPUTS(3)) dut3 (
    .clk(clk), .rst(rst), .in_bus(bus3), .selector(sel3), .in_valid(iv3),
    .in_ready(in_ready3), .out(out3), .out_sel(out_sel3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready3));

  logic [15:0] exp_q8[$];
  logic [15:0] exp_q3[$];

  typedef struct {
    logic       iv;
    logic [2:0] sel;
    logic       ordy;
    logic       ev;
    logic [7:0] eout;
    logic [2:0] esel;
    logic       eerr;
    logic       erdy;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic std_bus();
    for (int k = 0; k < 8; k++) bus8[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 5; k++) bus5[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 3; k++) bus3[k*8 +: 8] = 8'h10 + 8'(k);
  endtask

  task automatic apply_vec(input int i);
    @(negedge clk);
    iv8 = tbl[i].iv; sel8 = tbl[i].sel; out_ready8 = tbl[i].ordy;
    @(posedge clk);
    #1;
    check($sformatf("vec%0d.valid", i), 32'(out_valid8), 32'(tbl[i].ev));
    check($sformatf("vec%0d.out", i), 32'(out8), 32'(tbl[i].eout));
    check($sformatf("vec%0d.sel", i), 32'(out_sel8), 32'(tbl[i].esel));
    check($sformatf("vec%0d.err", i), 32'(out_err8), 32'(tbl[i].eerr));
    check($sformatf("vec%0d.in_ready", i), 32'(in_ready8), 32'(tbl[i].erdy));
  endtask

  initial begin
    logic        hold8, hold3, drain;
    logic [15:0] held8, held3, e;
    logic [7:0]  w;

    // streaming: one word per clock, 1-cycle latency, then an idle drain
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 3'(i), 1'b1, 1'b1, 8'h10 + 8'(i), 3'(i), 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h17, 3'd7, 1'b0, 1'b1};
    // backpressure: sel 3 to main, sel 5 to skid, then drain in order
    tbl[9]  = '{1'b1, 3'd3, 1'b0, 1'b1, 8'h13, 3'd3, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 3'd5, 1'b0, 1'b1, 8'h13, 3'd3, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 3'd0, 1'b0, 1'b1, 8'h13, 3'd3, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 3'd0, 1'b1, 1'b1, 8'h15, 3'd5, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h15, 3'd5, 1'b0, 1'b1};

    std_bus();
    iv8 = 0; sel8 = 0; out_ready8 = 0;
    iv5 = 0; sel5 = 0; out_ready5 = 0;
    iv3 = 0; sel3 = 0; out_ready3 = 0;

    // reset state
    #12;
    check("rst.valid", 32'(out_valid8), 0);
    check("rst.out", 32'(out8), 0);
    check("rst.in_ready", 32'(in_ready8), 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rel.in_ready_before_clk", 32'(in_ready8), 0);
    @(posedge clk);
    #1;
    check("rel.in_ready_after_clk", 32'(in_ready8), 1);

    for (int i = 0; i < 14; i++) apply_vec(i);

    // payload held while stalled even though in_bus changes
    @(negedge clk);
    iv8 = 1; sel8 = 3'd2; out_ready8 = 0;
    @(posedge clk);
    #1;
    check("stall.first", 32'(out8), 32'h12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv8 = 0; bus8 = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check($sformatf("stall.hold%0d", i), 32'({out_valid8, out_err8, out_sel8, out8}), 32'h1_2_12);
    end
    @(negedge clk);
    std_bus(); out_ready8 = 1;
    @(posedge clk);
    #1;
    check("stall.drained", 32'(out_valid8), 0);

    // out-of-range selector on the 5-input build
    @(negedge clk);
    iv5 = 1; sel5 = 3'd6; out_ready5 = 1;
    @(posedge clk);
    #1;
    check("n5.err_out", 32'(out5), 0);
    check("n5.err_flag", 32'(out_err5), 1);
    check("n5.err_sel", 32'(out_sel5), 6);
    check("n5.err_valid", 32'(out_valid5), 1);
    @(negedge clk);
    sel5 = 3'd2;
    @(posedge clk);
    #1;
    check("n5.ok_out", 32'(out5), 32'h12);
    check("n5.ok_err", 32'(out_err5), 0);
    @(negedge clk);
    iv5 = 0; sel5 = 3'd5;
    @(posedge clk);
    #1;
    check("n5.idle_valid", 32'(out_valid5), 0);

    // reset mid-stream with main and skid both occupied
    @(negedge clk);
    iv8 = 1; sel8 = 3'd1; out_ready8 = 0;
    @(negedge clk);
    sel8 = 3'd4;
    @(negedge clk);
    iv8 = 0;
    check("mid.skid_full", 32'(in_ready8), 0);
    #2 rst = 1;
    #1;
    check("mid.valid", 32'(out_valid8), 0);
    check("mid.out", 32'(out8), 0);
    check("mid.sel", 32'(out_sel8), 0);
    check("mid.in_ready", 32'(in_ready8), 0);
    @(negedge clk);
    rst = 0; out_ready8 = 1;
    #1;
    check("mid.rel_in_ready", 32'(in_ready8), 0);
    @(posedge clk);
    #1;
    check("mid.in_ready_up", 32'(in_ready8), 1);
    check("mid.no_stale", 32'(out_valid8), 0);
    @(posedge clk);
    #1;
    check("mid.skid_gone", 32'(out_valid8), 0);

    // random traffic, scoreboards on the 8- and 3-input builds
    hold8 = 0; hold3 = 0; held8 = 0; held3 = 0;
    for (int c = 0; c < 4020; c++) begin
      drain = (c >= 4000);
      @(negedge clk);
      iv8 = drain ? 1'b0 : 1'($urandom_range(0, 1));
      sel8 = 3'($urandom_range(0, 7));
      bus8 = {$urandom, $urandom};
      out_ready8 = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      iv3 = drain ? 1'b0 : 1'($urandom_range(0, 1));
      sel3 = 2'($urandom_range(0, 3));
      bus3 = 24'($urandom);
      out_ready3 = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      if (hold8) check("rnd8.stable", 32'({out_err8, out_sel8, out8}), 32'(held8));
      if (hold3) check("rnd3.stable", 32'({out_err3, out_sel3, out3}), 32'(held3));
      if (out_valid8 && out_ready8) begin
        if (exp_q8.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rnd8.pop: got word 0x%0h expected none (queue empty)", out8);
        end else begin
          e = exp_q8.pop_front();
          check("rnd8.word", 32'({out_err8, out_sel8, out8}), 32'(e));
        end
      end
      if (out_valid3 && out_ready3) begin
        if (exp_q3.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rnd3.pop: got word 0x%0h expected none (queue empty)", out3);
        end else begin
          e = exp_q3.pop_front();
          check("rnd3.word", 32'({out_err3, out_sel3, out3}), 32'(e));
        end
      end
      if (iv8 && in_ready8) begin
        w = bus8[int'(sel8)*8 +: 8];
        exp_q8.push_back({4'b0, 1'b0, sel8, w});
      end
      if (iv3 && in_ready3) begin
        if (sel3 < 2'd3) exp_q3.push_back({5'b0, 1'b0, sel3, bus3[int'(sel3)*8 +: 8]});
        else             exp_q3.push_back({5'b0, 1'b1, sel3, 8'h00});
      end
      hold8 = out_valid8 && !out_ready8;
      held8 = 16'({out_err8, out_sel8, out8});
      hold3 = out_valid3 && !out_ready3;
      held3 = 16'({out_err3, out_sel3, out3});
    end
    check("rnd8.empty", 32'(exp_q8.size()), 0);
    check("rnd3.empty", 32'(exp_q3.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
